// File: rtl/aula_201029_qsys_led_blink_pio.sv
// rtl/aula_201029_qsys_led_blink_pio.sv - Avalon-MM LED output PIO with toggle alias and optional blink engine (AULA_LED_BLINK_EN)
module aula_201029_qsys_led_blink_pio #(
  parameter int WIDTH    = 4,
  parameter int PERIOD_W = 24
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_MASK   = 2'd1;
  localparam logic [1:0] ADDR_PERIOD = 2'd2;
  localparam logic [1:0] ADDR_TOGGLE = 2'd3;

  logic             wr_en;
  logic [WIDTH-1:0] data_q;
  logic             phase;
  logic [31:0]      rd_next;
  logic             unused_writedata;

  assign wr_en            = chipselect && !write_n;
  assign unused_writedata = ^writedata;

`ifdef AULA_LED_BLINK_EN
  localparam logic [PERIOD_W-1:0] CNT_ONE = PERIOD_W'(1);

  logic [WIDTH-1:0]    mask_q;
  logic [PERIOD_W-1:0] period_q;
  logic [PERIOD_W-1:0] cnt_q;
  logic                phase_q;

  // Blink configuration registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask_q   <= '0;
      period_q <= '0;
    end else if (wr_en) begin
      if (address == ADDR_MASK)   mask_q   <= writedata[WIDTH-1:0];
      if (address == ADDR_PERIOD) period_q <= writedata[PERIOD_W-1:0];
    end
  end

  // Blink engine: a PERIOD write restarts it and wins over a same-edge expiry
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else if (wr_en && address == ADDR_PERIOD) begin
      cnt_q   <= writedata[PERIOD_W-1:0];
      phase_q <= 1'b0;
    end else if (period_q == '0) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else if (cnt_q == '0) begin
      cnt_q   <= period_q;
      phase_q <= ~phase_q;
    end else begin
      cnt_q   <= cnt_q - CNT_ONE;
    end
  end

  assign phase = phase_q;
`else
  assign phase = 1'b0;
`endif

  // DATA register, written directly or through the XOR toggle alias
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q <= '0;
    end else if (wr_en) begin
      if (address == ADDR_DATA)   data_q <= writedata[WIDTH-1:0];
      if (address == ADDR_TOGGLE) data_q <= data_q ^ writedata[WIDTH-1:0];
    end
  end

  // Read mux; unimplemented bits read as zero
  always_comb begin
    rd_next = '0;
    case (address)
      ADDR_DATA:   rd_next[WIDTH-1:0] = data_q;
`ifdef AULA_LED_BLINK_EN
      ADDR_MASK:   rd_next[WIDTH-1:0] = mask_q;
      ADDR_PERIOD: rd_next[PERIOD_W-1:0] = period_q;
`endif
      ADDR_TOGGLE: rd_next[WIDTH-1:0] = out_port;
      default:     rd_next = '0;
    endcase
  end

  // Registered LED drive and read data
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_port <= '0;
      readdata <= '0;
    end else begin
`ifdef AULA_LED_BLINK_EN
      out_port <= data_q ^ (mask_q & {WIDTH{phase}});
`else
      out_port <= data_q ^ {WIDTH{phase}};
`endif
      readdata <= rd_next;
    end
  end

endmodule

// File: tb/tb_aula_201029_qsys_led_blink_pio.sv
// tb/tb_aula_201029_qsys_led_blink_pio.sv - scoreboard bench for the LED blink PIO against a closed-form model
module tb_aula_201029_qsys_led_blink_pio;

  localparam int WIDTH    = 4;
  localparam int PERIOD_W = 24;
`ifdef AULA_LED_BLINK_EN
  localparam bit BLINK = 1'b1;
`else
  localparam bit BLINK = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [1:0]       address = '0;
  logic             chipselect = 1'b0;
  logic             write_n = 1'b1;
  logic [31:0]      writedata = '0;
  logic [31:0]      readdata;
  logic [WIDTH-1:0] out_port;

  aula_201029_qsys_led_blink_pio #(.WIDTH(WIDTH), .PERIOD_W(PERIOD_W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .out_port  (out_port)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] out;
    logic [31:0]      rd;
  } exp_t;

  exp_t sb_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model: blink phase is derived from elapsed edges since the last PERIOD write
  logic [WIDTH-1:0]    m_data, m_mask, m_out;
  logic [PERIOD_W-1:0] m_period;
  longint              m_edge, m_start;

  task automatic model_reset();
    m_data = '0; m_mask = '0; m_out = '0; m_period = '0;
    m_edge = 0; m_start = 0;
  endtask

  function automatic logic m_phase();
    longint span;
    if (m_period == '0) return 1'b0;
    span = longint'(m_period) + 1;
    return ((m_edge - m_start) / span) % 2 == 1;
  endfunction

  task automatic cycle(input logic [1:0] a, input logic cs, input logic wn, input logic [31:0] wd);
    exp_t e;
    logic ph;
    @(negedge clk);
    address = a; chipselect = cs; write_n = wn; writedata = wd;
    ph = m_phase();
    e.out = m_data ^ (m_mask & {WIDTH{ph}});
    case (a)
      2'd0: e.rd = 32'(m_data);
      2'd1: e.rd = BLINK ? 32'(m_mask) : 32'd0;
      2'd2: e.rd = BLINK ? 32'(m_period) : 32'd0;
      default: e.rd = 32'(m_out);
    endcase
    if (cs && !wn) begin
      case (a)
        2'd0: m_data = wd[WIDTH-1:0];
        2'd1: if (BLINK) m_mask = wd[WIDTH-1:0];
        2'd2: if (BLINK) begin m_period = wd[PERIOD_W-1:0]; m_start = m_edge + 1; end
        default: m_data = m_data ^ wd[WIDTH-1:0];
      endcase
    end
    m_edge = m_edge + 1;
    m_out = e.out;
    sb_q.push_back(e);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] wd);
    cycle(a, 1'b1, 1'b0, wd);
  endtask

  task automatic rd(input logic [1:0] a);
    cycle(a, 1'b1, 1'b1, $urandom);
  endtask

  // Monitor: compare DUT outputs after every checked edge
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (reset_n && sb_q.size() > 0) begin
      e = sb_q.pop_front();
      vectors++;
      if (out_port !== e.out || readdata !== e.rd) begin
        miscompares++;
        if (out_port !== e.out)
          $display("FAIL out_port: got %h expected %h (t=%0t)", out_port, e.out, $time);
        if (readdata !== e.rd)
          $display("FAIL readdata: got %h expected %h (t=%0t)", readdata, e.rd, $time);
      end
    end
  end

  task automatic check_zero(input string name);
    vectors++;
    if (out_port !== '0 || readdata !== '0) begin
      miscompares++;
      $display("FAIL %s: out_port %h readdata %h expected 0", name, out_port, readdata);
    end
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    check_zero("reset_state");
    reset_n = 1'b1;

    // reads of all addresses after reset
    for (int i = 0; i < 4; i++) rd(2'(i));

    // DATA then TOGGLE alias
    wr(2'd0, 32'hFFFF_FFF5);
    wr(2'd3, 32'h3);
    rd(2'd0);
    rd(2'd3);
    rd(2'd3);

    // full-mask blink with PERIOD=3
    wr(2'd1, 32'hF);
    wr(2'd0, 32'h0);
    wr(2'd2, 32'd3);
    for (int i = 0; i < 24; i++) rd(2'(i % 4));

    // stop blinking mid-run
    wr(2'd2, 32'd0);
    for (int i = 0; i < 10; i++) rd(2'd3);

    // PERIOD rewrite on the expiry edge
    wr(2'd2, 32'd3);
    for (int i = 0; i < 8 && ((m_edge + 1 - m_start) % 4) != 0; i++) rd(2'd3);
    wr(2'd2, 32'd2);
    for (int i = 0; i < 12; i++) rd(2'd3);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      logic [1:0]  a;
      logic [31:0] wd;
      a  = 2'($urandom_range(0, 3));
      wd = $urandom;
      if (a == 2'd2 && $urandom_range(0, 9) != 0) wd = 32'($urandom_range(0, 6));
      cycle(a, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, wd);
    end

    // asynchronous reset while blinking with out_port at mask value
    wr(2'd1, 32'hF);
    wr(2'd0, 32'h0);
    wr(2'd2, 32'd3);
    for (int i = 0; i < 12 && !(BLINK && m_out == 4'hF); i++) rd(2'd3);
    rd(2'd3);
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    chipselect = 1'b0;
    write_n = 1'b1;
    #1;
    check_zero("async_reset");
    sb_q.delete();
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) rd(2'(i % 4));

    repeat (3) @(negedge clk);
    vectors++;
    if (sb_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/aula_201029_qsys_led_blink_pio.md
# aula_201029_qsys_led_blink_pio

Avalon-MM output PIO slave that drives the board LEDs from the Nios II system: the write-side counterpart of the key input port. Software writes a data register, with a toggle alias, and may enable a hardware blink engine that inverts selected bits at a programmable period without CPU involvement. Sits on the Qsys data master alongside the key input PIO; `out_port` is exported to the top-level LED pins.

## Interface
- `WIDTH`, 4: number of output bits (1..32).
- `PERIOD_W`, 24: width of the blink period register and counter (1..32).
- `clk` input 1: system clock; all state updates on the rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `address` input 2: register select.
- `chipselect` input 1: slave selected.
- `write_n` input 1: active-low write strobe; a write occurs when `chipselect && !write_n`.
- `writedata` input 32: write data.
- `readdata` output 32: registered read data.
- `out_port` output WIDTH: registered LED drive.

## Operation
- Register map:
  - addr 0 DATA: read/write, bits [WIDTH-1:0].
  - addr 1 MASK: blink mask, read/write.
  - addr 2 PERIOD: read/write, bits [PERIOD_W-1:0].
  - addr 3 TOGGLE: a write XORs `writedata[WIDTH-1:0]` into DATA; a read returns the current `out_port`.
- Unused upper bits of writes are ignored; unused upper bits of reads return 0.
- Blink engine:
  - Down-counter `cnt` (PERIOD_W bits) and a 1-bit `phase`.
  - If PERIOD == 0, the engine is idle: `cnt` is held at 0 and `phase` is held at 0.
  - Otherwise, each cycle: if `cnt` == 0, load `cnt` <= PERIOD and toggle `phase`; else decrement `cnt`.
  - Result: `phase` toggles every PERIOD+1 cycles, and a full blink cycle is 2·(PERIOD+1) cycles.
- A write to PERIOD loads `cnt` <= new value and clears `phase` in the same edge. This restarts the engine and takes priority over a simultaneous expiry.
- `out_port` <= DATA ^ (MASK & {WIDTH{phase}}), computed each cycle from the current register values.
- Writes to DATA, MASK and TOGGLE do not disturb `cnt` or `phase`.
- Reads:
  - `readdata` <= read_mux(address) every clock, regardless of `chipselect`.
  - Reads have no side effects.

## Timing
- Reset values: DATA, MASK, PERIOD, `cnt`, `phase`, `readdata` and `out_port` are all 0.
- Write at edge N:
  - Register updates at edge N.
  - `out_port` reflects the update at edge N+1.
- Read latency: `readdata` is valid one cycle after `address` is presented (fixed read latency 1).
- Address 3 read returns the `out_port` value registered at the sampling edge.
- No wait states; `chipselect` and `write_n` are sampled every cycle; back-to-back writes are allowed.
- Reset asserted mid-blink: immediately forces all state and outputs to 0, asynchronously. After release, the engine is idle until PERIOD is written.

## Configuration
- Macro: `AULA_LED_BLINK_EN`.
- Defined: MASK, PERIOD, `cnt` and `phase` are implemented as above.
- Undefined:
  - No counter logic is implemented.
  - Addr 1 and addr 2 read 0, and writes to them are ignored.
  - `out_port` <= DATA; `phase` is tied to 0.
  - DATA and TOGGLE behave unchanged.

## Test plan
- Reset, then read all 4 addresses. Required: `readdata` = 0 for each, `out_port` = 0.
- Write DATA = 0x5, then TOGGLE = 0x3. Required: `out_port` = 0x5, then 0x6; an addr 0 read returns 0x6 and an addr 3 read returns 0x6.
- MASK = 0xF, DATA = 0x0, PERIOD = 3. Required: `out_port` alternates 0x0/0xF, holding each value 4 cycles, for at least 5 toggles.
- While blinking with PERIOD = 3, write PERIOD = 0. Required: `out_port` returns to DATA one cycle later and stays there.
- Write PERIOD = 2 on the exact cycle `cnt` == 0. Required: no toggle occurs, `phase` = 0, and the next toggle comes 3 cycles later.
- Assert `reset_n` mid-blink with `out_port` = 0xF. Required: `out_port` = 0 asynchronously and no toggling after release. With `AULA_LED_BLINK_EN` undefined: MASK/PERIOD reads return 0 and `out_port` always equals DATA.
